// File: rtl/delay_line_reader_if.sv
// Sample stream into and delayed sample stream out of delay_line_reader.
// The master drives samples and the delay select; the slave returns the delayed sample.
interface delay_line_reader_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DLY_W     = 5
);
  logic                 ce;
  logic [BUS_WIDTH-1:0] d;
  logic [DLY_W-1:0]     delay;
  logic [BUS_WIDTH-1:0] q;
  logic                 q_valid;
  logic                 delay_err;

  modport master (
    output ce, d, delay,
    input  q, q_valid, delay_err
  );

  modport slave (
    input  ce, d, delay,
    output q, q_valid, delay_err
  );
endinterface

// File: rtl/delay_line_reader.sv
// Run-time programmable delay line: a circular buffer written on every ce edge,
// read back `delay` ce-events later into a registered output.
module delay_line_reader #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned MAX_DELAY = 16,
  parameter int unsigned DLY_W     = 5
) (
  input logic               clk,
  input logic               rst_n,
  delay_line_reader_if.slave bus
);

  localparam int unsigned     PtrW    = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DLY_W-1:0] MaxDly = DLY_W'(MAX_DELAY);
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(MAX_DELAY - 1);
  // Wraps to zero when MAX_DELAY is a power of two, which is exactly the modular add needed.
  localparam logic [PtrW-1:0]  DepthP = PtrW'(MAX_DELAY);

  logic [BUS_WIDTH-1:0] mem [MAX_DELAY];

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr;
  logic [DLY_W-1:0]     fill_q, fill_d;
  logic [DLY_W-1:0]     eff;
  logic [PtrW-1:0]      eff_p;
  logic [BUS_WIDTH-1:0] q_q, q_d;
  logic                 q_valid_q, q_valid_d;
  logic                 delay_err_q, delay_err_d;

  always_comb begin
    delay_err_d = (bus.delay > MaxDly);
    eff         = delay_err_d ? MaxDly : bus.delay;
    eff_p       = eff[PtrW-1:0];

    // eff = MAX_DELAY folds back onto wr_ptr itself: the oldest entry, read before overwrite.
    if (wr_ptr_q >= eff_p) begin
      rd_ptr = wr_ptr_q - eff_p;
    end else begin
      rd_ptr = wr_ptr_q - eff_p + DepthP;
    end

    q_d       = '0;
    q_valid_d = 1'b0;
    if (eff == '0) begin
      q_d       = bus.d;
      q_valid_d = 1'b1;
    end else if (fill_q >= eff) begin
      q_d       = mem[rd_ptr];
      q_valid_d = 1'b1;
    end

    wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    fill_d   = (fill_q == MaxDly) ? fill_q : fill_q + DLY_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      q_q         <= '0;
      q_valid_q   <= 1'b0;
      delay_err_q <= 1'b0;
    end else if (bus.ce) begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      q_q         <= q_d;
      q_valid_q   <= q_valid_d;
      delay_err_q <= delay_err_d;
    end
  end

  // Storage is not reset; fill gating masks stale contents.
  always_ff @(posedge clk) begin
    if (bus.ce) begin
      mem[wr_ptr_q] <= bus.d;
    end
  end

  assign bus.q         = q_q;
  assign bus.q_valid   = q_valid_q;
  assign bus.delay_err = delay_err_q;

endmodule

// File: tb/tb_delay_line_reader.sv
// Directed and randomized checks of delay_line_reader against a sample-history model.
module tb_delay_line_reader;

  localparam int unsigned BW   = 8;
  localparam int unsigned MAXD = 16;
  localparam int unsigned DW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_line_reader_if #(.BUS_WIDTH(BW), .DLY_W(DW)) bus ();

  delay_line_reader #(
    .BUS_WIDTH(BW),
    .MAX_DELAY(MAXD),
    .DLY_W    (DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: every sample written since reset, oldest first.
  logic [BW-1:0] hist[$];
  logic [BW-1:0] m_q;
  logic          m_valid;
  logic          m_err;

  task automatic model_reset();
    hist.delete();
    m_q     = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic ce, input logic [BW-1:0] d, input logic [DW-1:0] dly);
    int eff;
    if (!ce) return;
    eff   = (int'(dly) > MAXD) ? MAXD : int'(dly);
    m_err = (int'(dly) > MAXD);
    if (eff == 0) begin
      m_q = d; m_valid = 1'b1;
    end else if (hist.size() >= eff) begin
      m_q = hist[hist.size() - eff]; m_valid = 1'b1;
    end else begin
      m_q = '0; m_valid = 1'b0;
    end
    hist.push_back(d);
  endtask

  task automatic step(input logic ce, input logic [BW-1:0] d, input logic [DW-1:0] dly);
    @(negedge clk);
    bus.ce    = ce;
    bus.d     = d;
    bus.delay = dly;
    @(posedge clk);
    model_edge(ce, d, dly);
    #1;
    check("q", 32'(bus.q), 32'(m_q));
    check("q_valid", 32'(bus.q_valid), 32'(m_valid));
    check("delay_err", 32'(bus.delay_err), 32'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.ce = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_delay_err", 32'(bus.delay_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [DW-1:0] cur_dly;

  initial begin
    bus.ce    = 1'b0;
    bus.d     = '0;
    bus.delay = '0;
    model_reset();

    // delay 3: three empty edges, then the stream shifted by three
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, BW'(i), DW'(3));
      if (i >= 4) check("dly3_q", 32'(bus.q), 32'(i - 3));
    end

    // delay 0 is a single register stage; ce=0 holds everything
    step(1'b1, 8'hA5, DW'(0));
    check("dly0_q", 32'(bus.q), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, BW'($urandom), DW'($urandom_range(0, 20)));
      check("hold_q", 32'(bus.q), 32'hA5);
    end

    // full depth through pointer wrap
    do_reset();
    for (int n = 0; n < 40; n++) begin
      step(1'b1, BW'(n), DW'(16));
      if (n >= 16) check("dly16_q", 32'(bus.q), 32'(n - 16));
      else         check("dly16_fill", 32'(bus.q_valid), 32'd0);
    end

    // delay switch 4 -> 2 mid-stream
    do_reset();
    for (int n = 0; n < 25; n++) begin
      step(1'b1, BW'(n), (n >= 20) ? DW'(2) : DW'(4));
      if (n == 20) check("switch_q", 32'(bus.q), 32'd18);
    end

    // refill after reset with delay 8
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, BW'(8'h40 + k), DW'(8));
      check("refill_valid", 32'(bus.q_valid), (k >= 8) ? 32'd1 : 32'd0);
    end

    // out-of-range delay clamps and flags, legal delay clears
    step(1'b1, 8'h77, DW'(20));
    check("err_set", 32'(bus.delay_err), 32'd1);
    step(1'b1, 8'h78, DW'(20));
    step(1'b1, 8'h79, DW'(5));
    check("err_clr", 32'(bus.delay_err), 32'd0);

    // asynchronous reset between edges
    @(negedge clk);
    bus.ce = 1'b0;
    @(posedge clk);
    #3;
    check("pre_async_valid", 32'(bus.q_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_q", 32'(bus.q), 32'd0);
    check("async_valid", 32'(bus.q_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized stream
    cur_dly = DW'(3);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) == 0) cur_dly = DW'($urandom_range(0, 20));
        step(($urandom_range(0, 3) != 0), BW'($urandom), cur_dly);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
